// File: rtl/multi_spi_tx.sv
// multi_spi_tx: multi-lane SPI shift-out transmitter (1, 2 or 4 lanes, MSB-first)
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   S                 lane mode latched on acceptance: 00 single, 01 dual, 11 quad, 10 reserved
//   tx_data, tx_valid word to send and its valid strobe
//   tx_ready          word can be accepted this cycle (idle or last beat)
//   O, O_en           lane data and beat-valid qualifier
//   busy              frame in progress
//   done              one-cycle pulse after the final beat of a word
//   err               one-cycle pulse after a reserved-mode word was consumed
module multi_spi_tx #(
   parameter int REGSIZE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         S,
   input  logic [REGSIZE-1:0] tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic [3:0]         O,
   output logic               O_en,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam int CW = $clog2(REGSIZE);
   localparam logic [CW-1:0] N1 = CW'(REGSIZE - 1);
   localparam logic [CW-1:0] N2 = CW'(REGSIZE / 2 - 1);
   localparam logic [CW-1:0] N4 = CW'(REGSIZE / 4 - 1);
   generate
      if ((REGSIZE % 4) != 0 || REGSIZE < 4) begin : g_bad_regsize
         $error("multi_spi_tx: REGSIZE must be a multiple of 4 and >= 4");
      end
   endgenerate
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t             state, state_n;
   logic [REGSIZE-1:0] sr, sr_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [1:0]         mode, mode_n;
   logic               done_n, err_n, acc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         mode  <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
         mode  <= mode_n;
         done  <= done_n;
         err   <= err_n;
      end
   end
   // A new word may be taken during the last beat so back-to-back words leave no gap.
   always_comb begin
      tx_ready = (state == IDLE) || (cnt == '0);
      acc      = tx_valid && tx_ready;
      state_n  = state;
      sr_n     = sr;
      cnt_n    = cnt;
      mode_n   = mode;
      done_n   = 1'b0;
      err_n    = 1'b0;
      if (state == SHIFT) begin
         sr_n  = mode == 2'b00 ? sr << 1 : mode == 2'b01 ? sr << 2 : sr << 4;
         cnt_n = cnt - CW'(1);
         if (cnt == '0) begin
            done_n  = 1'b1;
            state_n = IDLE;
         end
      end
      if (acc) begin
         if (S == 2'b10) begin
            err_n   = 1'b1;
            state_n = IDLE;
         end else begin
            sr_n    = tx_data;
            mode_n  = S;
            cnt_n   = S == 2'b00 ? N1 : S == 2'b01 ? N2 : N4;
            state_n = SHIFT;
         end
      end
   end
   assign O_en = (state == SHIFT);
   assign busy = (state == SHIFT);
   assign O    = state != SHIFT ? 4'b0000 :
                 mode == 2'b00  ? {3'b000, sr[REGSIZE-1]} :
                 mode == 2'b01  ? {2'b00, sr[REGSIZE-1 -: 2]} : sr[REGSIZE-1 -: 4];
endmodule

// File: doc/multi_spi_tx.md
Name: multi_spi_tx

Overview:
- Multi-lane SPI shift-out transmitter; transmit-side counterpart to the MultiSPI shift-in receiver.
- Accepts a REGSIZE-bit word over a valid/ready handshake.
- Serialises the word MSB-first over 1, 2 or 4 data lanes, selected per word by a 2-bit mode.
- Bit/lane ordering matches the receiver: a receiver clocked on the same edges, with the same mode, during O_en cycles holds the original word after the last beat.

Parameters:
REGSIZE, 8, word width in bits; must be a multiple of 4 and >= 4 (elaboration-time check).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
S  input  2  lane mode, sampled on word acceptance: 00 single, 01 dual, 11 quad, 10 reserved
tx_data  input  REGSIZE  word to transmit
tx_valid  input  1  tx_data/S valid
tx_ready  output  1  block can accept a word this cycle
O  output  4  lane data
O_en  output  1  O carries a valid beat this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the final beat of each word
err  output  1  one-cycle pulse after a word with S=10 was consumed

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; shift register, beat counter and latched mode cleared.
  - O=0, O_en=0, busy=0, done=0, err=0; tx_ready=1 from the next cycle.
  - Reset mid-frame aborts the word; no done is produced.
- Lanes L: 1 for mode 00, 2 for 01, 4 for 11. Beats per word N = REGSIZE/L.
- State IDLE:
  - tx_ready=1, O_en=0, busy=0, O=0.
- Acceptance: tx_valid & tx_ready at a posedge.
  - Valid S: load shift register with tx_data, latch mode, counter=N-1, state=SHIFT.
  - S=10: word consumed and discarded; err pulses the next cycle; next state is IDLE.
- State SHIFT:
  - O_en=1, busy=1.
  - O is driven from the top bits of the shift register:
    - single: O[0]=sr[MSB], O[3:1]=0
    - dual: O[1:0]=sr[MSB:MSB-1], O[3:2]=0
    - quad: O[3:0]=sr[MSB:MSB-3]
  - At each posedge: shift register shifts left by L (zero fill); counter decrements.
- Last beat (counter==0):
  - tx_ready=1; outside the last beat, tx_ready=0 in SHIFT.
  - Next posedge with acceptance: reload, latch the new mode, stay in SHIFT. No gap; O_en stays 1.
  - Next posedge with no acceptance: go to IDLE.
  - Either way, done=1 for exactly the following cycle.
- Latency: first beat appears on O in the cycle after acceptance. Word occupies exactly N consecutive O_en cycles.
- Mode changes on S while in SHIFT are ignored until the next acceptance.
- tx_data and S are don't-care when not accepted.
- rst has priority over acceptance.
- done and err are registered outputs. All outputs are glitch-free from registers; tx_ready may be decoded from state/counter.

Test Plan:
- Single, REGSIZE=8: accept 0xA5, S=00.
  - Next 8 cycles O[0]=1,0,1,0,0,1,0,1 with O_en=1.
  - done=1 on cycle 9, tx_ready=1.
- Dual: accept 0xA5, S=01 -> O[1:0]=2,2,1,1 over 4 cycles, O[3:2]=0, done on cycle 5.
- Quad back-to-back: tx_valid held with 0xA5 then 0x3C, S=11.
  - O=A,5,3,C on 4 consecutive O_en cycles, no gap.
  - done pulses after beat 2 and beat 4; IDLE afterwards.
- Reserved mode: tx_valid with S=10 -> consumed (tx_ready=1), err=1 next cycle, O_en stays 0, done stays 0.
- Reset mid-frame: single 0xFF, assert rst after beat 3.
  - Next cycle O_en=0, O=0, busy=0, no done.
  - Next accepted word 0x81 (quad) gives O=8,1.
- Loopback: quad 0x5A into a MultiSPI receiver (REGSIZE=8) clocked only on O_en cycles -> receiver register=0x5A after 2 beats; repeat for single and dual modes.
